// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives lw/sw over a req/ack data port and registers the M/W latch.
// Latency 1 cycle for non-memory ops, 2+ cycles for lw/sw; stall freezes upstream until ack or timeout.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       data_in,
  input  logic [31:0]       insn_in,
  input  logic              exception_in,
  input  logic              overflow_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [31:0]       mw_result,
  output logic [31:0]       mw_insn,
  output logic              mw_exception,
  output logic              mw_overflow,
  output logic              mw_valid
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;

  logic [31:0] w_res_nxt, w_insn_nxt;
  logic        w_exc_nxt, w_ovf_nxt, w_vld_nxt;
  logic        w_stall, w_launch;

  logic [4:0] w_opcode;
  logic       w_is_sw, w_is_lw, w_is_mem, w_fault, w_ack, w_timeout;

  assign w_opcode  = insn_in[31:27];
  assign w_is_sw   = (w_opcode == 5'b00111);
  assign w_is_lw   = (w_opcode == 5'b01000);
  assign w_is_mem  = w_is_sw | w_is_lw;
  assign w_fault   = (alu_in[31:ADDR_W] != '0);
  assign w_ack     = (r_state == S_ACCESS) && mem_ack;
  assign w_timeout = (r_state == S_ACCESS) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_stall     = 1'b0;
    w_res_nxt   = alu_in;
    w_insn_nxt  = insn_in;
    w_exc_nxt   = exception_in;
    w_ovf_nxt   = overflow_in;
    w_vld_nxt   = (insn_in != 32'b0);
    case (r_state)
      S_IDLE: begin
        if (w_is_mem && !exception_in) begin
          if (w_fault) begin
            w_exc_nxt = 1'b1;
          end else begin
            w_launch    = 1'b1;
            w_stall     = 1'b1;
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = '0;
            w_res_nxt   = '0;
            w_insn_nxt  = '0;
            w_exc_nxt   = 1'b0;
            w_ovf_nxt   = 1'b0;
            w_vld_nxt   = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        if (w_ack) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_res_nxt   = r_we ? alu_in : mem_rdata;
          w_exc_nxt   = 1'b0;
          w_vld_nxt   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_exc_nxt   = 1'b1;
          w_vld_nxt   = 1'b1;
        end else begin
          w_stall    = 1'b1;
          w_cnt_nxt  = r_cnt + 1'b1;
          w_res_nxt  = '0;
          w_insn_nxt = '0;
          w_exc_nxt  = 1'b0;
          w_ovf_nxt  = 1'b0;
          w_vld_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      mw_result    <= '0;
      mw_insn      <= '0;
      mw_exception <= 1'b0;
      mw_overflow  <= 1'b0;
      mw_valid     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_launch) begin
        r_addr  <= alu_in[ADDR_W-1:0];
        r_wdata <= data_in;
        r_we    <= w_is_sw;
      end
      mw_result    <= w_res_nxt;
      mw_insn      <= w_insn_nxt;
      mw_exception <= w_exc_nxt;
      mw_overflow  <= w_ovf_nxt;
      mw_valid     <= w_vld_nxt;
    end
  end

  // Stall is gated by clr so every output reads zero while reset is held.
  assign stall     = w_stall && !clr;
  assign mem_req   = (r_state == S_ACCESS);
  assign mem_we    = (r_state == S_ACCESS) ? r_we : 1'b0;
  assign mem_addr  = (r_state == S_ACCESS) ? r_addr : '0;
  assign mem_wdata = (r_state == S_ACCESS) ? r_wdata : '0;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT=4, ADDR_W=12.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] alu_in, data_in, insn_in, mem_rdata;
  logic        exception_in, overflow_in, mem_ack;
  logic        mem_req, mem_we, stall;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mw_result, mw_insn;
  logic        mw_exception, mw_overflow, mw_valid;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] ADD_I = {5'b00000, 27'h0000123};
  localparam logic [31:0] LW_I  = {5'b01000, 27'h0000456};
  localparam logic [31:0] SW_I  = {5'b00111, 27'h0000789};

  mem_stage_ctrl #(.ADDR_W(12), .TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .alu_in(alu_in), .data_in(data_in), .insn_in(insn_in),
    .exception_in(exception_in), .overflow_in(overflow_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .mw_result(mw_result), .mw_insn(mw_insn), .mw_exception(mw_exception),
    .mw_overflow(mw_overflow), .mw_valid(mw_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] alu, input logic [31:0] dat,
                       input logic exc, input logic ovf);
    insn_in = insn; alu_in = alu; data_in = dat; exception_in = exc; overflow_in = ovf;
  endtask

  initial begin
    clr = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(32'b0, 32'b0, 32'b0, 1'b0, 1'b0);
    #12;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(mw_valid), 32'd0);
    chk("rst_result", mw_result, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // 1: plain ALU op
    drive(ADD_I, 32'd5, 32'd0, 1'b0, 1'b1);
    #1 chk("add_stall", 32'(stall), 32'd0);
    chk("add_req", 32'(mem_req), 32'd0);
    tick();
    chk("add_result", mw_result, 32'd5);
    chk("add_ovf", 32'(mw_overflow), 32'd1);
    chk("add_valid", 32'(mw_valid), 32'd1);
    chk("add_insn", mw_insn, ADD_I);

    // 2: lw with ack in the third ACCESS cycle
    drive(LW_I, 32'h10, 32'd0, 1'b0, 1'b0);
    #1 chk("lw_stall0", 32'(stall), 32'd1);
    chk("lw_req_idle", 32'(mem_req), 32'd0);
    tick();
    chk("lw_req", 32'(mem_req), 32'd1);
    chk("lw_addr", 32'(mem_addr), 32'h10);
    chk("lw_we", 32'(mem_we), 32'd0);
    chk("lw_stall1", 32'(stall), 32'd1);
    chk("lw_bubble", 32'(mw_valid), 32'd0);
    tick();
    chk("lw_stall2", 32'(stall), 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 chk("lw_stall_ack", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("lw_result", mw_result, 32'hDEADBEEF);
    chk("lw_valid", 32'(mw_valid), 32'd1);
    chk("lw_req_done", 32'(mem_req), 32'd0);

    // 3: sw acked in its first ACCESS cycle
    drive(SW_I, 32'h20, 32'hCAFE, 1'b0, 1'b0);
    #1 chk("sw_stall0", 32'(stall), 32'd1);
    tick();
    mem_ack = 1'b1;
    #1 chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_wdata", mem_wdata, 32'hCAFE);
    chk("sw_addr", 32'(mem_addr), 32'h20);
    chk("sw_stall_ack", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("sw_result", mw_result, 32'h20);
    chk("sw_insn", mw_insn, SW_I);
    chk("sw_valid", 32'(mw_valid), 32'd1);

    // 4: address fault, then incoming exception
    drive(LW_I, 32'h0001_0000, 32'd0, 1'b0, 1'b0);
    #1 chk("flt_stall", 32'(stall), 32'd0);
    tick();
    chk("flt_req", 32'(mem_req), 32'd0);
    chk("flt_exc", 32'(mw_exception), 32'd1);
    chk("flt_result", mw_result, 32'h0001_0000);
    drive(LW_I, 32'h10, 32'd0, 1'b1, 1'b0);
    #1 chk("exc_stall", 32'(stall), 32'd0);
    tick();
    chk("exc_req", 32'(mem_req), 32'd0);
    chk("exc_exc", 32'(mw_exception), 32'd1);
    chk("exc_result", mw_result, 32'h10);

    // 5: timeout after 4 ACCESS cycles, late ack ignored
    drive(LW_I, 32'h30, 32'd0, 1'b0, 1'b0);
    tick();
    chk("to_req1", 32'(mem_req), 32'd1);
    tick();
    chk("to_req2", 32'(mem_req), 32'd1);
    tick();
    chk("to_req3", 32'(mem_req), 32'd1);
    chk("to_stall3", 32'(stall), 32'd1);
    tick();
    chk("to_req4", 32'(mem_req), 32'd1);
    chk("to_stall4", 32'(stall), 32'd0);
    tick();
    chk("to_req_off", 32'(mem_req), 32'd0);
    chk("to_exc", 32'(mw_exception), 32'd1);
    chk("to_result", mw_result, 32'h30);
    chk("to_valid", 32'(mw_valid), 32'd1);
    drive(32'b0, 32'h77, 32'd0, 1'b0, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    #1 chk("late_stall", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("late_result", mw_result, 32'h77);
    chk("late_exc", 32'(mw_exception), 32'd0);
    chk("late_req", 32'(mem_req), 32'd0);

    // 6: async clear in the second ACCESS cycle, then a clean lw
    drive(LW_I, 32'h40, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("clr_req_pre", 32'(mem_req), 32'd1);
    #2 clr = 1'b1;
    #1 chk("clr_req", 32'(mem_req), 32'd0);
    chk("clr_stall", 32'(stall), 32'd0);
    chk("clr_valid", 32'(mw_valid), 32'd0);
    chk("clr_insn", mw_insn, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    drive(LW_I, 32'h50, 32'd0, 1'b0, 1'b0);
    tick();
    chk("post_addr", 32'(mem_addr), 32'h50);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    drive(32'b0, 32'b0, 32'b0, 1'b0, 1'b0);
    chk("post_result", mw_result, 32'h1234_5678);
    chk("post_valid", 32'(mw_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
